if_bus_ctrl: RTL

- Instruction-fetch bus controller between the PC register/IF stage and a shared instruction bus with a request/acknowledge handshake.
- Converts each PC (with fetch enable) into one bus read and raises a stall request while the read is outstanding.
- Holds the fetched word stable while the pipeline is stalled.
- Drops in-flight reads cancelled by an exception flush.

---
 rtl/if_bus_ctrl_pkg.sv | 28 ++
 rtl/if_bus_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_bus_ctrl_pkg.sv
// if_bus_ctrl_pkg
// Shared definitions for the instruction-fetch bus controller:
//   - 2-bit FSM state encodings
//   - ZeroWord / NOP instruction word
//   - index of the IF/ID hold bit in the stall vector
//   - Enable / Disable macros for single-bit control levels
// No ports; imported by if_bus_ctrl.

`ifndef IF_BUS_CTRL_DEFINES_SV
`define IF_BUS_CTRL_DEFINES_SV
`define Enable  1'b1
`define Disable 1'b0
`endif

package if_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUS_REQ    = 2'd1,
    WAIT_STALL = 2'd2,
    FLUSH_WAIT = 2'd3
  } if_state_e;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic [31:0] NopInst   = ZeroWord;
  localparam int          StallIfId = 1;

endpackage

// File: rtl/if_bus_ctrl.sv
// if_bus_ctrl
// Instruction-fetch bus controller. Turns each enabled PC into one bus read,
// requests a pipeline stall while the read is outstanding, holds the fetched
// word while IF/ID is stalled, and discards reads cancelled by a flush.
//
// State table:
//   IDLE       | no read outstanding; issues a read when cpu_ce_i=1
//   BUS_REQ    | read outstanding, result wanted
//   WAIT_STALL | word fetched, IF/ID held; cpu_data_o replays the buffer
//   FLUSH_WAIT | read outstanding but cancelled; result is dropped on ack
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall[5:0]      pipeline stall vector (bit 1 = IF/ID hold)
//   flush           exception flush
//   cpu_ce_i        fetch enable from the PC register
//   cpu_addr_i      current PC
//   cpu_data_o      fetched instruction (registered)
//   stallreq_o      stall request (combinational)
//   bus_req_o       bus read request (registered, held until ack)
//   bus_addr_o      bus read address (registered)
//   bus_ack_i       bus read complete, data valid this cycle
//   bus_data_i      bus read data
//   fetch_timeout_o one-cycle pulse when a read is abandoned after
//                   TIMEOUT_CYC cycles (only with IF_BUS_TIMEOUT_EN)
//
// Build option: define IF_BUS_TIMEOUT_EN to bound bus waits.

module if_bus_ctrl
  import if_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_data_i
`ifdef IF_BUS_TIMEOUT_EN
  ,
  output logic              fetch_timeout_o
`endif
);

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NopInst);

  if_state_e         state_q, state_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] rd_buf, rd_buf_d;

  // Only the IF/ID hold bit matters to the fetch stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5:2], stall[0]};

`ifdef IF_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_d;
  logic             cnt_hit;
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // The PC may only advance on the edge that latches the data, so the stall
  // request drops in the ack cycle; a flush always releases the PC.
  assign stallreq_o = ((state_q == IDLE)    && cpu_ce_i   && !flush) ||
                      ((state_q == BUS_REQ) && !bus_ack_i && !flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bus_req_o  <= `Disable;
      bus_addr_o <= '0;
      cpu_data_o <= NOP_W;
      rd_buf     <= '0;
`ifdef IF_BUS_TIMEOUT_EN
      cnt_q           <= '0;
      fetch_timeout_o <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bus_req_o  <= req_d;
      bus_addr_o <= addr_d;
      cpu_data_o <= data_d;
      rd_buf     <= rd_buf_d;
`ifdef IF_BUS_TIMEOUT_EN
      cnt_q           <= cnt_d;
      fetch_timeout_o <= to_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = bus_req_o;
    addr_d   = bus_addr_o;
    data_d   = cpu_data_o;
    rd_buf_d = rd_buf;
`ifdef IF_BUS_TIMEOUT_EN
    cnt_d = cnt_q + CNT_W'(1);
    to_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (flush) begin
          data_d = NOP_W;
        end else if (cpu_ce_i) begin
          req_d   = `Enable;
          addr_d  = cpu_addr_i;
          state_d = BUS_REQ;
`ifdef IF_BUS_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end

      BUS_REQ: begin
        if (bus_ack_i) begin
          req_d = `Disable;
          if (flush) begin
            data_d  = NOP_W;
            state_d = IDLE;
          end else begin
            rd_buf_d = bus_data_i;
            data_d   = bus_data_i;
            state_d  = stall[StallIfId] ? WAIT_STALL : IDLE;
          end
        end
`ifdef IF_BUS_TIMEOUT_EN
        else if (cnt_hit) begin
          req_d   = `Disable;
          data_d  = NOP_W;
          state_d = IDLE;
          to_d    = 1'b1;
        end
`endif
        else if (flush) begin
          // The bus has already accepted the request; keep it up and
          // throw the data away when it finally arrives.
          data_d  = NOP_W;
          state_d = FLUSH_WAIT;
`ifdef IF_BUS_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end

      WAIT_STALL: begin
        data_d = rd_buf;
        if (flush) begin
          data_d  = NOP_W;
          state_d = IDLE;
        end else if (!stall[StallIfId]) begin
          state_d = IDLE;
        end
      end

      FLUSH_WAIT: begin
        if (bus_ack_i) begin
          req_d   = `Disable;
          state_d = IDLE;
        end
`ifdef IF_BUS_TIMEOUT_EN
        else if (cnt_hit) begin
          req_d   = `Disable;
          data_d  = NOP_W;
          state_d = IDLE;
          to_d    = 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
